// File: rtl/sipo_rx_if.sv
// Port bundle for the serial-in, parallel-out word receiver.
// master = the receiver itself; slave = the bit source plus word consumer facing it.
interface sipo_rx_if #(
    parameter int N = 16
);
    logic         sin;
    logic         sin_valid;
    logic         sync;
    logic [N-1:0] q;
    logic         q_valid;
    logic         q_ready;
    logic         overrun;
    logic         ovr_clr;
    logic         busy;

    modport master (
        input  sin, sin_valid, sync, q_ready, ovr_clr,
        output q, q_valid, overrun, busy
    );

    modport slave (
        output sin, sin_valid, sync, q_ready, ovr_clr,
        input  q, q_valid, overrun, busy
    );
endinterface

// File: rtl/sipo_rx.sv
// Assembles an MSB-first serial stream into N-bit words on a valid/ready port,
// with a sticky overrun flag for words dropped while the consumer stalls.
module sipo_rx #(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      rst,
    sipo_rx_if.master bus
);
    localparam int SW = N - 1;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [SW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  word_q, word_d;
    logic          q_valid_q, q_valid_d;
    logic          overrun_q, overrun_d;
    logic          complete;
    logic          ovr_set;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        q_valid_d = q_valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;
        ovr_set   = 1'b0;

        // sync realigns the bit stream; a bit arriving with it is the new MSB
        if (bus.sync) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (bus.sin_valid) begin
                shreg_d = SW'(bus.sin);
                cnt_d   = CW'(1);
            end
        end else if (bus.sin_valid) begin
            if (cnt_q == LAST) begin
                complete = 1'b1;
                cnt_d    = '0;
            end else begin
                shreg_d = SW'({shreg_q, bus.sin});
                cnt_d   = cnt_q + CW'(1);
            end
        end

        if (complete) begin
            if (!q_valid_q || bus.q_ready) begin
                word_d    = {shreg_q, bus.sin};
                q_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (q_valid_q && bus.q_ready) begin
            q_valid_d = 1'b0;
        end

        // a fresh overrun beats a clear on the same edge
        if (bus.ovr_clr) overrun_d = 1'b0;
        if (ovr_set)     overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.q       = word_q;
    assign bus.q_valid = q_valid_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (cnt_q != '0);
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (N=16): inputs change 1 time unit after a rising
// edge and outputs are checked there, well away from the next edge.
module tb_sipo_rx;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   qv_low   = 0;
    logic zb_mon   = 1'b0;

    sipo_rx_if #(.N(N)) bus ();

    sipo_rx #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // counts cycles in which q_valid dropped during the zero-bubble stream
    always @(negedge clk) if (zb_mon && !bus.q_valid) qv_low++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        step();
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic rdy_mid, input logic rdy_last);
        for (int i = N - 1; i >= 0; i--) begin
            bus.q_ready = (i == 0) ? rdy_last : rdy_mid;
            send_bit(w[i]);
        end
    endtask

    task automatic idle(input logic rdy);
        bus.sin_valid = 1'b0;
        bus.q_ready   = rdy;
        step();
    endtask

    initial begin
        logic [N-1:0] w;
        bus.sin = 0; bus.sin_valid = 0; bus.sync = 0; bus.q_ready = 0; bus.ovr_clr = 0;

        // reset state
        #2 rst = 1'b1;
        step(); step();
        check("rst_q", bus.q, 0);
        check("rst_q_valid", bus.q_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;

        // basic word, busy tracked bit by bit
        w = 16'h8001;
        bus.q_ready = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            send_bit(w[i]);
            check($sformatf("basic_busy_%0d", N - i), bus.busy, (i == 0) ? 0 : 1);
            if (i != 0) check("basic_no_early_valid", bus.q_valid, 0);
        end
        check("basic_q", bus.q, 16'h8001);
        check("basic_q_valid", bus.q_valid, 1);
        idle(1'b1);
        check("basic_valid_one_cycle", bus.q_valid, 0);
        check("basic_q_hold", bus.q, 16'h8001);

        // gapped input
        w = 16'hA5C3;
        for (int i = N - 1; i >= 0; i--) begin
            bus.q_ready = 1'b1;
            send_bit(w[i]);
            if (i == 0) check("gap_q_valid", bus.q_valid, 1);
            if (i == 8) check("gap_busy_mid", bus.busy, 1);
            idle(1'b1);
        end
        check("gap_q", bus.q, 16'hA5C3);
        check("gap_busy_end", bus.busy, 0);

        // stall and overrun
        send_word(16'h1234, 1'b0, 1'b0);
        check("stall_q", bus.q, 16'h1234);
        check("stall_q_valid", bus.q_valid, 1);
        check("stall_no_overrun", bus.overrun, 0);
        send_word(16'hFFFF, 1'b0, 1'b0);
        check("ovr_set", bus.overrun, 1);
        check("ovr_q_kept", bus.q, 16'h1234);
        check("ovr_q_valid", bus.q_valid, 1);
        idle(1'b1);
        check("ovr_accept_valid", bus.q_valid, 0);
        check("ovr_accept_q", bus.q, 16'h1234);
        check("ovr_still_set", bus.overrun, 1);
        bus.ovr_clr = 1'b1;
        idle(1'b0);
        bus.ovr_clr = 1'b0;
        check("ovr_clr", bus.overrun, 0);

        // set beats clear on the same edge
        send_word(16'h0F0F, 1'b0, 1'b0);
        bus.ovr_clr = 1'b1;
        send_word(16'h3C3C, 1'b0, 1'b0);
        check("ovr_set_wins", bus.overrun, 1);
        check("ovr_set_wins_q", bus.q, 16'h0F0F);
        idle(1'b1);
        bus.ovr_clr = 1'b0;
        check("ovr_clr_after", bus.overrun, 0);
        check("ovr_clr_valid", bus.q_valid, 0);

        // re-alignment with sync carrying the new MSB
        bus.q_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        bus.sync = 1'b1;
        send_bit(1'b1);
        bus.sync = 1'b0;
        check("sync_cnt", dut.cnt_q, 1);
        check("sync_busy", bus.busy, 1);
        for (int i = 0; i < 14; i++) send_bit(1'b0);
        check("sync_not_done", bus.q_valid, 0);
        send_bit(1'b1);
        check("sync_q", bus.q, 16'h8001);
        check("sync_q_valid", bus.q_valid, 1);
        check("sync_no_overrun", bus.overrun, 0);
        idle(1'b1);

        // reset mid-word with q_valid and overrun both set
        send_word(16'h5555, 1'b0, 1'b0);
        send_word(16'hAAAA, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("pre_rst_overrun", bus.overrun, 1);
        check("pre_rst_valid", bus.q_valid, 1);
        bus.sin_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_q", bus.q, 0);
        check("async_rst_q_valid", bus.q_valid, 0);
        check("async_rst_overrun", bus.overrun, 0);
        check("async_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        send_word(16'h00FF, 1'b1, 1'b1);
        check("post_rst_q", bus.q, 16'h00FF);
        check("post_rst_q_valid", bus.q_valid, 1);
        check("post_rst_overrun", bus.overrun, 0);
        idle(1'b1);

        // zero-bubble accept on completion edges only
        send_word(16'h0001, 1'b0, 1'b1);
        check("zb_q1", bus.q, 16'h0001);
        check("zb_v1", bus.q_valid, 1);
        zb_mon = 1'b1;
        send_word(16'h0002, 1'b0, 1'b1);
        check("zb_q2", bus.q, 16'h0002);
        send_word(16'h0003, 1'b0, 1'b1);
        check("zb_q3", bus.q, 16'h0003);
        check("zb_v3", bus.q_valid, 1);
        zb_mon = 1'b0;
        check("zb_no_bubble", qv_low, 0);
        check("zb_no_overrun", bus.overrun, 0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out word receiver that undoes the parallel-to-serial shifter. It accepts an MSB-first serial bit stream qualified by a per-bit valid and assembles N bits into a word. It presents each word on a valid/ready output port and flags overruns when the consumer stalls. It sits at the receive end of the team's serial links and in loopback benches facing the PISO transmitter.

## Interface
- `N`, default 16: word width in bits; legal range N >= 2.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `sin`  in  1: serial data bit, MSB of each word first.
- `sin_valid`  in  1: `sin` is sampled on this edge when 1.
- `sync`  in  1: word-alignment strobe; discards any partial word.
- `q`  out  N: last completed word.
- `q_valid`  out  1: `q` holds a word not yet accepted.
- `q_ready`  in  1: consumer accepts `q` on an edge where `q_valid` and `q_ready` are both 1.
- `overrun`  out  1: sticky; a completed word was dropped.
- `ovr_clr`  in  1: clears `overrun`.
- `busy`  out  1: partial word in progress (bit counter != 0).

## Operation
- Internal state:
  - `shreg[N-2:0]`: partial word.
  - `cnt`: accepted-bit counter, range 0..N-1, width clog2(N).
- Reset (asynchronous, takes effect immediately): `shreg`=0, `cnt`=0, `q`=0, `q_valid`=0, `overrun`=0, `busy`=0.
- Bit accept (`sin_valid`=1, `sync`=0):
  - If `cnt` < N-1: `shreg` <= {`shreg[N-3:0]`, `sin`} and `cnt` <= `cnt`+1.
  - If `cnt` = N-1 (word completes): the word is {`shreg`, `sin`}, the first accepted bit becomes `q[N-1]`. `cnt` wraps to 0.
- Word complete, output free (`q_valid`=0, or `q_valid`=1 with `q_ready`=1 on the same edge): `q` <= word and `q_valid` <= 1.
- Word complete, output blocked (`q_valid`=1, `q_ready`=0): the word is dropped, `q` is unchanged, `overrun` <= 1, and `cnt` still wraps to 0.
- Accept without a completing word: `q_valid` && `q_ready` gives `q_valid` <= 0. `q` holds its value.
- `sync`=1:
  - `cnt` <= 0 and `shreg` <= 0. Any partial word is discarded without raising `overrun`.
  - If `sin_valid`=1 on the same edge, that bit is the first bit (MSB) of the new word: `shreg` <= {0…, `sin`} and `cnt` <= 1.
  - `sync` never affects `q`, `q_valid`, or `overrun`.
- `overrun`:
  - Set as above; cleared when `ovr_clr`=1.
  - If set and clear occur on the same edge, set wins.
- `sin_valid`=0 (and `sync`=0): `shreg` and `cnt` hold; gaps of any length between bits are allowed.
- `busy` = (`cnt` != 0), registered-equivalent, because it is derived only from state.

## Timing
- All outputs change only on the rising `clk` edge or on `rst` assertion.
- Latency: `q`/`q_valid` update on the same edge that samples the N-th bit, so they are visible in the following cycle.
- Back-to-back words (`sin_valid` held 1) complete every N cycles.
  - With `q_ready` tied to 1, `q_valid` pulses high for 1 cycle per word.
- Simultaneous completion and accept refreshes `q` with no bubble; `q_valid` stays 1.
- `q_ready` while `q_valid`=0 has no effect.
- `rst` asserted mid-word discards the partial word. After `rst` is released, the next accepted bit is treated as an MSB.
- Throughput: at most 1 bit per cycle.

## Test plan
- **Basic word** (N=16): after reset, shift 16'h8001 MSB-first with `sin_valid`=1 for 16 consecutive cycles and `q_ready`=1.
  - `q`=16'h8001 and `q_valid`=1 for exactly 1 cycle, starting the cycle after the 16th bit.
  - `busy` is 1 from bit 1 through bit 15, then 0.
- **Gapped input**: send 16'hA5C3 with `sin_valid` toggling 1/0.
  - `q`=16'hA5C3 after 32 cycles; no extra or lost bits.
- **Stall and overrun**: `q_ready`=0, send 16'h1234 then 16'hFFFF.
  - `q`=16'h1234 and `q_valid` stays 1; `overrun` rises after the second word.
  - Raise `q_ready`: `q_valid` drops and `q` is still 16'h1234.
  - Assert `ovr_clr`: `overrun`=0.
  - Variant: asserting `ovr_clr` on the overrun edge leaves `overrun`=1.
- **Re-alignment**: send 5 bits, then `sync`=1 together with `sin_valid`=1 and `sin`=1, then 15 bits of 16'h8001's tail (all 0 except the last).
  - `q`=16'h8001 with no `overrun`; `cnt`=1 right after the `sync` edge.
- **Reset mid-word**: assert `rst` after 7 bits, with `q_valid`=1 and `overrun`=1.
  - All outputs go to 0 immediately.
  - A following full 16-bit 16'h00FF yields `q`=16'h00FF.
- **Zero-bubble accept**: continuous stream of 16'h0001, 16'h0002, 16'h0003 with `q_ready`=1 only on each completion edge.
  - `q_valid` stays 1 across the words and `q` steps 1, 2, 3.
  - `overrun` never set.
